stopwatch_bcd_counter: RTL and testbench

- Timekeeping core of the Nexys3 stopwatch, directly upstream of the 7-segment scan/display stage.
- Debounces the pause and clear buttons and synchronises the adjust switches.
- Keeps mm:ss as four BCD digits, supports run, pause and adjust modes, and emits a per-digit blink mask for the display stage.
- Single clock domain; the clock divider supplies timing as one-cycle strobes, not derived clocks.

---
 rtl/stopwatch_pkg.sv | 45 ++++
 rtl/stopwatch_bcd_counter_btn_debounce.sv | 61 ++++++
 rtl/stopwatch_bcd_counter.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, constants and helpers for the stopwatch timekeeping core.
//   bcd_t        : one 4-bit BCD digit
//   bcd_field_t  : a two-digit field (tens, ones), used for both mm and ss
//   field_inc_t  : result of incrementing a field (value plus carry out)
//   field_inc()  : BCD increment of a 00..59 field, wrapping 59 -> 00 with carry
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_field_t;

    typedef struct packed {
        logic       carry;
        bcd_field_t val;
    } field_inc_t;

    localparam bcd_t       ONES_MAX      = 4'd9;
    localparam bcd_t       TENS_MAX      = 4'd5;
    localparam logic [3:0] BLINK_SEC     = 4'b0011;
    localparam logic [3:0] BLINK_MIN     = 4'b1100;
    localparam int         DB_CYCLES_DEF = 1_000_000;

    // Increment a mod-60 BCD field; carry is set only on the 59 -> 00 wrap.
    function automatic field_inc_t field_inc(input bcd_field_t f);
        field_inc_t r;
        r.carry = 1'b0;
        r.val   = f;
        if (f.ones == ONES_MAX) begin
            r.val.ones = 4'd0;
            if (f.tens == TENS_MAX) begin
                r.val.tens = 4'd0;
                r.carry    = 1'b1;
            end else begin
                r.val.tens = f.tens + 4'd1;
            end
        end else begin
            r.val.ones = f.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_btn_debounce.sv
// Button conditioner: synchroniser, stability-counter debouncer and
// rising-edge pulse generator.
//   clk     : system clock
//   rst_i   : asynchronous active-high reset (already release-synchronised)
//   btn_i   : raw, bouncy, asynchronous button
//   pulse_o : one-clk pulse when the debounced level rises
module btn_debounce #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   synced_s;

    assign synced_s = sync_q[SYNC_STAGES-1];

    // Next-state: counter only advances while the synced input disagrees
    // with the debounced level; any agreement restarts the stability window.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        if (synced_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            level_d = synced_s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        pulse_d = level_d & ~level_q;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timekeeping core: mm:ss BCD counter with run, pause and adjust
// modes, feeding the 7-segment display stage.
//   clk         : 100 MHz system clock
//   arst_i      : asynchronous active-high reset (release synchronised here)
//   tick_1hz    : 1 Hz one-clk strobe, advances time in run mode
//   tick_2hz    : 2 Hz one-clk strobe, advances the selected field in adjust
//   btn_pause_i : raw pause button, toggles paused_o
//   btn_clr_i   : raw clear button, zeroes all digits
//   adj_i       : raw switch, 1 = adjust mode
//   sel_i       : raw switch, adjust field: 0 = seconds, 1 = minutes
//   digit_o     : {min_tens, min_ones, sec_tens, sec_ones}
//   paused_o    : count halted
//   blink_o     : per-digit blank request (1 = blank), nibble order of digit_o
//   rollover_o  : one-clk pulse on 59:59 -> 00:00
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        arst_i,
    input  logic        tick_1hz,
    input  logic        tick_2hz,
    input  logic        btn_pause_i,
    input  logic        btn_clr_i,
    input  logic        adj_i,
    input  logic        sel_i,
    output logic [15:0] digit_o,
    output logic        paused_o,
    output logic [3:0]  blink_o,
    output logic        rollover_o
);

    logic [1:0]             rst_sync_q, rst_sync_d;
    logic                   rst_s;
    logic [SYNC_STAGES-1:0] adj_sync_q, adj_sync_d;
    logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
    logic                   adj_s, sel_s;
    logic                   pause_pulse_s, clr_pulse_s;
    field_inc_t             sec_inc_s, min_inc_s;

    logic [15:0] digit_q, digit_d;
    logic        paused_q, paused_d;
    logic        rollover_q, rollover_d;
    logic        phase_q, phase_d;
    logic [3:0]  blink_q, blink_d;

    // Reset synchroniser next-state: zeros shift in once arst_i is released.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
    end

    // Reset synchroniser: asserts immediately, releases on the second clk edge.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_s = rst_sync_q[1];

    btn_debounce #(
        .DB_CYCLES  (DB_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_db_pause (
        .clk    (clk),
        .rst_i  (rst_s),
        .btn_i  (btn_pause_i),
        .pulse_o(pause_pulse_s)
    );

    btn_debounce #(
        .DB_CYCLES  (DB_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_db_clr (
        .clk    (clk),
        .rst_i  (rst_s),
        .btn_i  (btn_clr_i),
        .pulse_o(clr_pulse_s)
    );

    assign adj_s = adj_sync_q[SYNC_STAGES-1];
    assign sel_s = sel_sync_q[SYNC_STAGES-1];

    // Core next-state: clear beats any tick; the mode decides which tick counts.
    always_comb begin
        adj_sync_d = {adj_sync_q[SYNC_STAGES-2:0], adj_i};
        sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], sel_i};
        sec_inc_s  = field_inc(digit_q[7:0]);
        min_inc_s  = field_inc(digit_q[15:8]);
        digit_d    = digit_q;
        rollover_d = 1'b0;

        if (clr_pulse_s) begin
            digit_d = 16'h0000;
        end else if (adj_s) begin
            // Adjust: each field wraps on its own, never carries, never rolls over.
            if (tick_2hz) begin
                if (sel_s) begin
                    digit_d[15:8] = min_inc_s.val;
                end else begin
                    digit_d[7:0] = sec_inc_s.val;
                end
            end else begin
                digit_d = digit_q;
            end
        end else if (tick_1hz && !paused_q) begin
            digit_d[7:0] = sec_inc_s.val;
            if (sec_inc_s.carry) begin
                digit_d[15:8] = min_inc_s.val;
                rollover_d    = min_inc_s.carry;
            end else begin
                digit_d[15:8] = digit_q[15:8];
            end
        end else begin
            digit_d = digit_q;
        end

        // Pause toggles from the pre-edge value, so a same-cycle tick sees the old state.
        if (pause_pulse_s) begin
            paused_d = ~paused_q;
        end else begin
            paused_d = paused_q;
        end

        if (adj_s) begin
            phase_d = tick_2hz ? ~phase_q : phase_q;
        end else begin
            phase_d = 1'b0;
        end

        // Blink mask is built from the next phase so it lines up with the edge.
        if (phase_d) begin
            blink_d = sel_s ? BLINK_MIN : BLINK_SEC;
        end else begin
            blink_d = 4'b0000;
        end
    end

    // Core state and registered outputs.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            adj_sync_q <= '0;
            sel_sync_q <= '0;
            digit_q    <= 16'h0000;
            paused_q   <= 1'b0;
            rollover_q <= 1'b0;
            phase_q    <= 1'b0;
            blink_q    <= 4'b0000;
        end else begin
            adj_sync_q <= adj_sync_d;
            sel_sync_q <= sel_sync_d;
            digit_q    <= digit_d;
            paused_q   <= paused_d;
            rollover_q <= rollover_d;
            phase_q    <= phase_d;
            blink_q    <= blink_d;
        end
    end

    assign digit_o    = digit_q;
    assign paused_o   = paused_q;
    assign rollover_o = rollover_q;
    assign blink_o    = blink_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter (DB_CYCLES=4, SYNC_STAGES=2).
// A behavioural model keeps minutes/seconds as plain integers; table vectors,
// hand-written button/reset sequences and a random phase are checked against it.
module tb_stopwatch_bcd_counter;

    localparam int DB   = 4;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        arst_i = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        tick_2hz = 1'b0;
    logic        btn_pause_i = 1'b0;
    logic        btn_clr_i = 1'b0;
    logic        adj_i = 1'b0;
    logic        sel_i = 1'b0;
    logic [15:0] digit_o;
    logic        paused_o;
    logic [3:0]  blink_o;
    logic        rollover_o;

    stopwatch_bcd_counter #(.DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .arst_i     (arst_i),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .btn_pause_i(btn_pause_i),
        .btn_clr_i  (btn_clr_i),
        .adj_i      (adj_i),
        .sel_i      (sel_i),
        .digit_o    (digit_o),
        .paused_o   (paused_o),
        .blink_o    (blink_o),
        .rollover_o (rollover_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          adj;
        bit          sel;
        int          n1;
        int          n2;
        logic [15:0] exp_digit;
        int          exp_rolls;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_min = 0, m_sec = 0;
    bit m_phase = 0, m_paused = 0;
    bit adj_raw = 0, sel_raw = 0;
    bit h1_adj = 0, h2_adj = 0, h1_sel = 0, h2_sel = 0;
    int roll_seen = 0;

    function automatic logic [15:0] exp_dig();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_phase = 0; m_paused = 0;
        adj_raw = 0; sel_raw = 0;
        h1_adj = 0; h2_adj = 0; h1_sel = 0; h2_sel = 0;
    endtask

    // One clock cycle: drive, advance model by the stopwatch rules, optionally compare.
    task automatic cyc(input bit t1, input bit t2, input bit chk);
        bit         ae, se, roll;
        logic [3:0] bl;
        tick_1hz = t1; tick_2hz = t2; adj_i = adj_raw; sel_i = sel_raw;
        @(posedge clk);
        ae = h2_adj; se = h2_sel; roll = 0;
        if (ae) begin
            if (t2) begin
                if (se) m_min = (m_min + 1) % 60;
                else    m_sec = (m_sec + 1) % 60;
                m_phase = !m_phase;
            end
        end else begin
            m_phase = 0;
            if (t1 && !m_paused) begin
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0;
                    m_min++;
                    if (m_min == 60) begin
                        m_min = 0;
                        roll  = 1;
                    end
                end
            end
        end
        h2_adj = h1_adj; h1_adj = adj_raw;
        h2_sel = h1_sel; h1_sel = sel_raw;
        bl = m_phase ? (se ? 4'b1100 : 4'b0011) : 4'b0000;
        #1;
        tick_1hz = 1'b0; tick_2hz = 1'b0;
        if (rollover_o === 1'b1) roll_seen++;
        if (chk) begin
            check("digit", {16'h0, digit_o}, {16'h0, exp_dig()});
            check("blink", {28'h0, blink_o}, {28'h0, bl});
            check("rollover", {31'h0, rollover_o}, {31'h0, roll});
            check("paused", {31'h0, paused_o}, {31'h0, m_paused});
        end
    endtask

    task automatic apply(input vec_t v);
        int r0;
        adj_raw = v.adj; sel_raw = v.sel;
        r0 = roll_seen;
        repeat (3) cyc(0, 0, 1);
        for (int i = 0; i < v.n1; i++) begin cyc(1, 0, 1); cyc(0, 0, 1); end
        for (int i = 0; i < v.n2; i++) begin cyc(0, 1, 1); cyc(0, 0, 1); end
        repeat (2) cyc(0, 0, 1);
        check("vec_digit", {16'h0, digit_o}, {16'h0, v.exp_digit});
        check("vec_rolls", roll_seen - r0, v.exp_rolls);
    endtask

    // Press a button cleanly (held long enough) and let it settle released.
    task automatic press(input bit is_clr);
        if (is_clr) btn_clr_i = 1'b1; else btn_pause_i = 1'b1;
        repeat (10) cyc(0, 0, 0);
        btn_clr_i = 1'b0; btn_pause_i = 1'b0;
        repeat (12) cyc(0, 0, 0);
    endtask

    initial begin
        int   pat[8];
        int   toggles;
        logic prevp;
        bit   lvl;
        vec_t v;

        vecs[0] = '{adj: 0, sel: 0, n1: 75, n2: 0,  exp_digit: 16'h0115, exp_rolls: 0};
        vecs[1] = '{adj: 1, sel: 1, n1: 0,  n2: 58, exp_digit: 16'h5915, exp_rolls: 0};
        vecs[2] = '{adj: 1, sel: 0, n1: 0,  n2: 44, exp_digit: 16'h5959, exp_rolls: 0};
        vecs[3] = '{adj: 0, sel: 0, n1: 1,  n2: 0,  exp_digit: 16'h0000, exp_rolls: 1};
        vecs[4] = '{adj: 1, sel: 1, n1: 3,  n2: 12, exp_digit: 16'h1200, exp_rolls: 0};
        vecs[5] = '{adj: 1, sel: 0, n1: 0,  n2: 59, exp_digit: 16'h1259, exp_rolls: 0};
        vecs[6] = '{adj: 1, sel: 0, n1: 0,  n2: 1,  exp_digit: 16'h1200, exp_rolls: 0};
        vecs[7] = '{adj: 0, sel: 0, n1: 2,  n2: 0,  exp_digit: 16'h1202, exp_rolls: 0};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_digit", {16'h0, digit_o}, 32'h0);
        check("rst_paused", {31'h0, paused_o}, 32'h0);
        check("rst_blink", {28'h0, blink_o}, 32'h0);
        check("rst_roll", {31'h0, rollover_o}, 32'h0);
        arst_i = 1'b0;
        repeat (2) cyc(0, 0, 1);

        // Table-driven run/adjust vectors
        for (int i = 0; i < 8; i++) apply(vecs[i]);

        // Pause with bouncing: glitches of 1-3 clk must not toggle
        pat = '{1, 2, 3, 2, 2, 3, 1, 2};
        toggles = 0;
        prevp = paused_o;
        lvl = 1;
        for (int i = 0; i < 8; i++) begin
            btn_pause_i = lvl;
            for (int j = 0; j < pat[i]; j++) begin
                cyc(0, 0, 0);
                if (paused_o !== prevp) toggles++;
                prevp = paused_o;
            end
            lvl = !lvl;
        end
        btn_pause_i = 1'b1;
        for (int j = 0; j < 22; j++) begin
            if (j == 10) btn_pause_i = 1'b0;
            cyc(0, 0, 0);
            if (paused_o !== prevp) toggles++;
            prevp = paused_o;
        end
        check("pause_toggles", toggles, 1);
        check("pause_level", {31'h0, paused_o}, 32'h1);
        m_paused = 1;
        for (int i = 0; i < 5; i++) begin cyc(1, 0, 1); cyc(0, 0, 1); end
        check("paused_hold", {16'h0, digit_o}, 32'h1202);
        press(0);
        check("resume_level", {31'h0, paused_o}, 32'h0);
        m_paused = 0;
        cyc(1, 0, 1);
        check("resume_count", {16'h0, digit_o}, 32'h1203);

        // Clear coinciding with tick_1hz at 12:34
        v = '{adj: 1, sel: 0, n1: 0, n2: 31, exp_digit: 16'h1234, exp_rolls: 0};
        apply(v);
        adj_raw = 0;
        repeat (3) cyc(0, 0, 1);
        btn_clr_i = 1'b1;
        repeat (SYNC + DB) cyc(0, 0, 0);
        check("clr_not_early", {16'h0, digit_o}, 32'h1234);
        cyc(1, 0, 0);
        check("clr_vs_tick", {16'h0, digit_o}, 32'h0000);
        check("clr_paused", {31'h0, paused_o}, 32'h0);
        m_min = 0; m_sec = 0;
        btn_clr_i = 1'b0;
        repeat (12) cyc(0, 0, 1);

        // Randomised run/adjust traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) adj_raw = !adj_raw;
            if ($urandom_range(0, 9) == 0) sel_raw = 1'($urandom_range(0, 1));
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1);
        end

        // Asynchronous reset mid-count at 05:07
        v = '{adj: 1, sel: 1, n1: 0, n2: (65 - m_min) % 60, exp_digit: 16'h0000, exp_rolls: 0};
        v.exp_digit = {8'h05, 4'(m_sec / 10), 4'(m_sec % 10)};
        apply(v);
        v = '{adj: 1, sel: 0, n1: 0, n2: (66 - m_sec) % 60, exp_digit: 16'h0506, exp_rolls: 0};
        apply(v);
        v = '{adj: 0, sel: 0, n1: 1, n2: 0, exp_digit: 16'h0507, exp_rolls: 0};
        apply(v);
        @(posedge clk);
        #3 arst_i = 1'b1;
        #1;
        check("arst_digit", {16'h0, digit_o}, 32'h0);
        check("arst_paused", {31'h0, paused_o}, 32'h0);
        check("arst_blink", {28'h0, blink_o}, 32'h0);
        #2 arst_i = 1'b0;
        model_reset();
        repeat (2) cyc(0, 0, 1);
        cyc(1, 0, 1);
        check("post_rst_count", {16'h0, digit_o}, 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
